// File: rtl/led_pwm_blinker.sv
// LED pin driver: global PWM brightness, prescaler and per-LED blink.
// Config is shadowed and applied only at PWM period wraps.
module led_pwm_blinker #(
  parameter int NUM_LEDS       = 8,
  parameter int PWM_BITS       = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int BLINK_WIDTH    = 16
) (
  input  logic                      CLK,
  input  logic                      RESETn,
  input  logic                      enable,
  input  logic [NUM_LEDS-1:0]       led_in,
  input  logic [PWM_BITS-1:0]       duty_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale_in,
  input  logic [BLINK_WIDTH-1:0]    blink_half_in,
  input  logic [NUM_LEDS-1:0]       blink_mask_in,
  input  logic                      cfg_load,
  output logic                      cfg_pending,
  output logic [NUM_LEDS-1:0]       led_out,
  output logic                      period_tick,
  output logic                      blink_phase
);

  typedef struct packed {
    logic [PWM_BITS-1:0]       duty;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [BLINK_WIDTH-1:0]    half;
    logic [NUM_LEDS-1:0]       mask;
  } cfg_t;

  localparam logic [PWM_BITS-1:0] PWM_LAST =
    {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] PWM_ONE =
    {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE =
    {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BLINK_WIDTH:0] BLK_ONE =
    {{BLINK_WIDTH{1'b0}}, 1'b1};

  cfg_t act;
  cfg_t pend;
  cfg_t cfg_in;

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [PWM_BITS-1:0]       pwm_cnt;
  logic [BLINK_WIDTH-1:0]    blink_cnt;
  logic [BLINK_WIDTH:0]      blink_inc;

  logic step;
  logic wrap;
  logic boundary;
  logic apply;
  logic pwm_on;
  logic blink_on;
  logic blink_last;

  assign cfg_in = {duty_in, prescale_in, blink_half_in, blink_mask_in};

  assign step     = enable & (pre_cnt == act.prescale);
  assign wrap     = step & (pwm_cnt == PWM_LAST);
  // A disabled block has no period in flight, so config lands at once.
  assign boundary = wrap | ~enable;
  assign apply    = boundary & (cfg_load | cfg_pending);

  assign pwm_on     = pwm_cnt < act.duty;
  assign blink_on   = act.half != '0;
  assign blink_inc  = {1'b0, blink_cnt} + BLK_ONE;
  assign blink_last = blink_inc == {1'b0, act.half};

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      act.duty     <= '1;
      act.prescale <= '0;
      act.half     <= '0;
      act.mask     <= '0;
      pend         <= '0;
      cfg_pending  <= 1'b0;
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b1;
      period_tick  <= 1'b0;
      led_out      <= '0;
    end else begin
      period_tick <= wrap;
      led_out <= led_in
               & {NUM_LEDS{enable & pwm_on}}
               & (~act.mask | {NUM_LEDS{blink_phase}});

      if (cfg_load)
        pend <= cfg_in;
      if (boundary & cfg_load)
        act <= cfg_in;
      else if (boundary & cfg_pending)
        act <= pend;
      cfg_pending <= (cfg_load | cfg_pending) & ~boundary;

      if (!enable) begin
        pre_cnt     <= '0;
        pwm_cnt     <= '0;
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else begin
        pre_cnt <= step ? '0 : pre_cnt + PRE_ONE;
        if (wrap)
          pwm_cnt <= '0;
        else if (step)
          pwm_cnt <= pwm_cnt + PWM_ONE;

        if (apply | ~blink_on) begin
          blink_cnt   <= '0;
          blink_phase <= 1'b1;
        end else if (wrap) begin
          if (blink_last) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_inc[BLINK_WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule
